// File: rtl/mips_cpu_pkg.sv
// Shared types and decode helpers for the MIPS pipeline memory stage.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW
    } memop_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    function automatic logic is_load(input memop_t op);
        return op inside {LB, LBU, LH, LHU, LW};
    endfunction

    function automatic logic is_store(input memop_t op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic logic misaligned(input memop_t op, input logic [1:0] a);
        case (op)
            LH, LHU, SH: return a[0];
            LW, SW:      return |a;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and little-endian extraction/extension for loads.
module mem_lane_align
    import mips_cpu_pkg::*;
(
    input  memop_t      memop,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = load_word[{byte_off, 3'b000} +: 8];
    assign half_sel = byte_off[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        case (memop)
            SB: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{store_data[7:0]}};
            end
            SH: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            SW: begin
                be    = 4'b1111;
                wdata = store_data;
            end
            LB, LBU, LH, LHU, LW: be = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        load_data = 32'h0;
        case (memop)
            LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     load_data = {24'h0, byte_sel};
            LH:      load_data = {{16{half_sel[15]}}, half_sel};
            LHU:     load_data = {16'h0, half_sel};
            LW:      load_data = load_word;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: req/ack data-bus access with alignment checks, stall and timeout.
module mem_stage
    import mips_cpu_pkg::*;
#(
    parameter int unsigned DBUS_AW     = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               cpu_clk_50M,
    input  logic               cpu_rst,
    input  logic               mem_i_dm2rf,
    input  logic               mem_i_hilowe,
    input  logic               mem_i_rfwe,
    input  logic [4:0]         mem_i_rfwa,
    input  logic [63:0]        mem_i_mulres,
    input  logic [31:0]        mem_i_alures,
    input  logic [31:0]        mem_i_dmdin,
    input  memop_t             mem_i_memop,
    output logic               dbus_req,
    output logic               dbus_we,
    output logic [3:0]         dbus_be,
    output logic [DBUS_AW-1:0] dbus_addr,
    output logic [31:0]        dbus_wdata,
    input  logic               dbus_ack,
    input  logic [31:0]        dbus_rdata,
    output logic               mem_stall,
    output logic               wb_i_dm2rf,
    output logic               wb_i_hilowe,
    output logic               wb_i_rfwe,
    output logic [4:0]         wb_i_rfwa,
    output logic [63:0]        wb_i_mulres,
    output logic [31:0]        wb_i_wdata,
    output logic               mem_o_adel,
    output logic               mem_o_ades,
    output logic               mem_o_buserr
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    mem_state_t  state_q;
    logic [31:0] load_buf_q;
    logic [CntW-1:0] cnt_q;
    logic        err_q;

    logic        load_op, store_op, mis, issue, busy, timeout_hit, stall_c, adel_c;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_data, load_src;

    assign load_op     = is_load(mem_i_memop);
    assign store_op    = is_store(mem_i_memop);
    assign mis         = misaligned(mem_i_memop, mem_i_alures[1:0]);
    assign issue       = (state_q == IDLE) && (load_op || store_op) && !mis;
    assign busy        = (state_q == BUSY);
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYC - 1));
    assign stall_c     = issue || busy;
    assign adel_c      = (state_q == IDLE) && load_op && mis;
    // The retiring load reads the captured word; rdata is only live during the ack cycle.
    assign load_src    = (state_q == DONE) ? load_buf_q : dbus_rdata;

    mem_lane_align u_lane_align (
        .memop      (mem_i_memop),
        .byte_off   (mem_i_alures[1:0]),
        .store_data (mem_i_dmdin),
        .load_word  (load_src),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state_q    <= IDLE;
            load_buf_q <= 32'h0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (issue) begin
                        if (dbus_ack) begin
                            load_buf_q <= dbus_rdata;
                            state_q    <= DONE;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dbus_ack) begin
                        load_buf_q <= dbus_rdata;
                        state_q    <= DONE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dbus_req     = 1'b0;
        dbus_we      = 1'b0;
        dbus_be      = 4'b0000;
        dbus_addr    = '0;
        dbus_wdata   = 32'h0;
        mem_stall    = 1'b0;
        wb_i_dm2rf   = 1'b0;
        wb_i_hilowe  = 1'b0;
        wb_i_rfwe    = 1'b0;
        wb_i_rfwa    = 5'h0;
        wb_i_mulres  = 64'h0;
        wb_i_wdata   = 32'h0;
        mem_o_adel   = 1'b0;
        mem_o_ades   = 1'b0;
        mem_o_buserr = 1'b0;
        if (!cpu_rst) begin
            dbus_req  = stall_c;
            mem_stall = stall_c;
            if (stall_c) begin
                dbus_we    = store_op;
                dbus_be    = lane_be;
                dbus_addr  = DBUS_AW'({mem_i_alures[31:2], 2'b00});
                dbus_wdata = lane_wdata;
            end
            mem_o_adel   = adel_c;
            mem_o_ades   = (state_q == IDLE) && store_op && mis;
            mem_o_buserr = busy && !dbus_ack && timeout_hit;
            wb_i_dm2rf   = mem_i_dm2rf;
            wb_i_hilowe  = mem_i_hilowe;
            wb_i_rfwa    = mem_i_rfwa;
            wb_i_mulres  = mem_i_mulres;
            // Write back only when the instruction actually retires without error.
            wb_i_rfwe    = mem_i_rfwe && !store_op && !stall_c && !adel_c
                           && !((state_q == DONE) && err_q);
            wb_i_wdata   = mem_i_dm2rf ? load_data : mem_i_alures;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: loads, stores, alignment faults, reset abort, timeout.
module tb_mem_stage;
    import mips_cpu_pkg::*;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        mem_i_dm2rf, mem_i_hilowe, mem_i_rfwe;
    logic [4:0]  mem_i_rfwa;
    logic [63:0] mem_i_mulres;
    logic [31:0] mem_i_alures, mem_i_dmdin;
    memop_t      mem_i_memop;
    logic        dbus_req, dbus_we, dbus_ack;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic        mem_stall, wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe;
    logic [4:0]  wb_i_rfwa;
    logic [63:0] wb_i_mulres;
    logic [31:0] wb_i_wdata;
    logic        mem_o_adel, mem_o_ades, mem_o_buserr;

    typedef struct {
        logic [31:0] wdata;
        logic        rfwe;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_stage #(.DBUS_AW(32), .TIMEOUT_CYC(255)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (cpu_rst),
        .mem_i_dm2rf (mem_i_dm2rf),
        .mem_i_hilowe(mem_i_hilowe),
        .mem_i_rfwe  (mem_i_rfwe),
        .mem_i_rfwa  (mem_i_rfwa),
        .mem_i_mulres(mem_i_mulres),
        .mem_i_alures(mem_i_alures),
        .mem_i_dmdin (mem_i_dmdin),
        .mem_i_memop (mem_i_memop),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_be     (dbus_be),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_ack    (dbus_ack),
        .dbus_rdata  (dbus_rdata),
        .mem_stall   (mem_stall),
        .wb_i_dm2rf  (wb_i_dm2rf),
        .wb_i_hilowe (wb_i_hilowe),
        .wb_i_rfwe   (wb_i_rfwe),
        .wb_i_rfwa   (wb_i_rfwa),
        .wb_i_mulres (wb_i_mulres),
        .wb_i_wdata  (wb_i_wdata),
        .mem_o_adel  (mem_o_adel),
        .mem_o_ades  (mem_o_ades),
        .mem_o_buserr(mem_o_buserr)
    );

    function automatic logic outs_zero();
        return ~|{dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata, mem_stall, wb_i_dm2rf,
                  wb_i_hilowe, wb_i_rfwe, wb_i_rfwa, wb_i_mulres, wb_i_wdata, mem_o_adel,
                  mem_o_ades, mem_o_buserr};
    endfunction

    task automatic set_op(input memop_t op, input logic [31:0] a, input logic [31:0] din);
        mem_i_memop  = op;
        mem_i_alures = a;
        mem_i_dmdin  = din;
        mem_i_dm2rf  = op inside {LB, LBU, LH, LHU, LW};
        mem_i_rfwe   = 1'b1;
        mem_i_rfwa   = 5'd9;
        mem_i_hilowe = 1'b0;
        mem_i_mulres = 64'h0;
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        set_op(MEM_NONE, 32'h0, 32'h0);
        dbus_ack = 1'b0;
    endtask

    // One bus access: ack arrives ack_delay cycles after the request is first raised.
    task automatic do_access(input string name, input memop_t op, input logic [31:0] a,
                             input logic [31:0] din, input logic [31:0] rdata,
                             input int ack_delay, input logic [3:0] exp_be,
                             input logic exp_we, input logic [31:0] exp_bw,
                             input logic [31:0] exp_wd, input logic exp_rfwe);
        exp_t e;
        int   stalls = 0;
        int   reqs = 0;
        bit   done = 0;
        e.wdata = exp_wd;
        e.rfwe  = exp_rfwe;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        set_op(op, a, din);
        for (int k = 0; k <= ack_delay + 2 && !done; k++) begin
            @(negedge clk);
            if (!mem_stall) begin
                done = 1;
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s scoreboard empty at retire", name);
                end else begin
                    e = sb_q.pop_front();
                    if (wb_i_wdata !== e.wdata || wb_i_rfwe !== e.rfwe) begin
                        failures++;
                        $display("FAIL %s retire wdata=%h rfwe=%b expected wdata=%h rfwe=%b",
                                 name, wb_i_wdata, wb_i_rfwe, e.wdata, e.rfwe);
                    end
                end
                checks++;
                if (dbus_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s req in DONE got %b expected 0", name, dbus_req);
                end
            end else begin
                stalls++;
                if (dbus_req === 1'b1) reqs++;
                if (k == 0) begin
                    checks++;
                    if (dbus_be !== exp_be || dbus_we !== exp_we) begin
                        failures++;
                        $display("FAIL %s be/we got %b/%b expected %b/%b",
                                 name, dbus_be, dbus_we, exp_be, exp_we);
                    end
                    checks++;
                    if (dbus_addr !== {a[31:2], 2'b00} || dbus_wdata !== exp_bw) begin
                        failures++;
                        $display("FAIL %s addr/wdata got %h/%h expected %h/%h",
                                 name, dbus_addr, dbus_wdata, {a[31:2], 2'b00}, exp_bw);
                    end
                end
                dbus_ack   = (k == ack_delay);
                dbus_rdata = rdata;
                @(posedge clk);
                #1;
                dbus_ack = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s never retired got done=0 expected 1", name);
        end
        checks++;
        if (stalls != ack_delay + 1 || reqs != stalls) begin
            failures++;
            $display("FAIL %s stall/req cycles got %0d/%0d expected %0d/%0d",
                     name, stalls, reqs, ack_delay + 1, ack_delay + 1);
        end
    endtask

    task automatic test_reset();
        cpu_rst = 1'b1;
        set_op(LW, 32'h100, 32'h5555_AAAA);
        mem_i_hilowe = 1'b1;
        mem_i_mulres = 64'hFFFF_0000_1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (outs_zero() !== 1'b1) begin
                failures++;
                $display("FAIL reset_outputs cycle %0d got nonzero expected all zero", i);
            end
        end
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;
        set_op(MEM_NONE, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle stall/req got %b/%b expected 0/0", mem_stall, dbus_req);
        end
    endtask

    task automatic test_loads();
        do_access("lw_ack_idle", LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 4'b1111, 1'b0, 32'h0,
                  32'hDEAD_BEEF, 1'b1);
        go_idle();
        do_access("lb_busy3", LB, 32'h103, 32'h0, 32'h8011_2233, 3, 4'b1111, 1'b0, 32'h0,
                  32'hFFFF_FF80, 1'b1);
        go_idle();
        do_access("lbu_busy3", LBU, 32'h103, 32'h0, 32'h8011_2233, 3, 4'b1111, 1'b0, 32'h0,
                  32'h0000_0080, 1'b1);
        go_idle();
    endtask

    task automatic test_stores();
        do_access("sh_hi", SH, 32'h102, 32'h0000_ABCD, 32'h0, 1, 4'b1100, 1'b1, 32'hABCD_ABCD,
                  32'h0000_0102, 1'b0);
        go_idle();
        do_access("sb_lane1", SB, 32'h201, 32'h0000_005A, 32'h0, 2, 4'b0010, 1'b1,
                  32'h5A5A_5A5A, 32'h0000_0201, 1'b0);
        go_idle();
        do_access("sw_word", SW, 32'h204, 32'h1357_9BDF, 32'h0, 0, 4'b1111, 1'b1,
                  32'h1357_9BDF, 32'h0000_0204, 1'b0);
        go_idle();
    endtask

    task automatic test_back_to_back();
        do_access("lh_b2b", LH, 32'h102, 32'h0, 32'h8001_1234, 0, 4'b1111, 1'b0, 32'h0,
                  32'hFFFF_8001, 1'b1);
        do_access("lhu_b2b", LHU, 32'h000, 32'h0, 32'h1234_F00D, 2, 4'b1111, 1'b0, 32'h0,
                  32'h0000_F00D, 1'b1);
        go_idle();
    endtask

    task automatic test_misaligned();
        @(posedge clk);
        #1;
        set_op(LW, 32'h101, 32'h0);
        @(negedge clk);
        checks++;
        if (dbus_req !== 1'b0 || mem_stall !== 1'b0 || wb_i_rfwe !== 1'b0) begin
            failures++;
            $display("FAIL lw_mis req/stall/rfwe got %b/%b/%b expected 0/0/0",
                     dbus_req, mem_stall, wb_i_rfwe);
        end
        checks++;
        if (mem_o_adel !== 1'b1 || mem_o_ades !== 1'b0) begin
            failures++;
            $display("FAIL lw_mis adel/ades got %b/%b expected 1/0", mem_o_adel, mem_o_ades);
        end
        @(posedge clk);
        #1;
        set_op(SW, 32'h102, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if (mem_o_ades !== 1'b1 || mem_o_adel !== 1'b0 || dbus_req !== 1'b0) begin
            failures++;
            $display("FAIL sw_mis ades/adel/req got %b/%b/%b expected 1/0/0",
                     mem_o_ades, mem_o_adel, dbus_req);
        end
        go_idle();
        @(negedge clk);
        checks++;
        if (mem_o_ades !== 1'b0 || mem_o_adel !== 1'b0) begin
            failures++;
            $display("FAIL mis_clear ades/adel got %b/%b expected 0/0", mem_o_ades, mem_o_adel);
        end
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk);
        #1;
        set_op(LW, 32'h200, 32'h0);
        dbus_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b1) begin
                failures++;
                $display("FAIL rst_busy pre stall cycle %0d got %b expected 1", i, mem_stall);
            end
        end
        cpu_rst = 1'b1;
        #1;
        checks++;
        if (outs_zero() !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy same-cycle got nonzero outputs expected all zero");
        end
        @(negedge clk);
        checks++;
        if (outs_zero() !== 1'b1) begin
            failures++;
            $display("FAIL rst_busy next-cycle got nonzero outputs expected all zero");
        end
        @(posedge clk);
        #1;
        cpu_rst = 1'b0;
        set_op(MEM_NONE, 32'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy after stall/req got %b/%b expected 0/0", mem_stall, dbus_req);
        end
    endtask

    task automatic test_timeout();
        int  stalls = 0;
        int  berr = 0;
        bit  done = 0;
        @(posedge clk);
        #1;
        set_op(LW, 32'h300, 32'h0);
        dbus_ack = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (mem_o_buserr === 1'b1) berr++;
            if (mem_stall === 1'b1) begin
                stalls++;
            end else begin
                done = 1;
                checks++;
                if (wb_i_rfwe !== 1'b0 || dbus_req !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_done rfwe/req got %b/%b expected 0/0",
                             wb_i_rfwe, dbus_req);
                end
            end
        end
        checks++;
        if (!done || stalls != 256) begin
            failures++;
            $display("FAIL timeout_stall got done=%0d stalls=%0d expected done=1 stalls=256",
                     done, stalls);
        end
        checks++;
        if (berr != 1) begin
            failures++;
            $display("FAIL timeout_buserr pulses got %0d expected 1", berr);
        end
        go_idle();
    endtask

    task automatic test_passthrough();
        @(posedge clk);
        #1;
        set_op(MEM_NONE, 32'h0000_1234, 32'h0);
        mem_i_hilowe = 1'b1;
        mem_i_mulres = 64'h1122_3344_5566_7788;
        mem_i_rfwa   = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_stall !== 1'b0 || dbus_req !== 1'b0) begin
                failures++;
                $display("FAIL pass_nostall cycle %0d stall/req got %b/%b expected 0/0",
                         i, mem_stall, dbus_req);
            end
        end
        checks++;
        if (wb_i_wdata !== 32'h0000_1234 || wb_i_rfwe !== 1'b1 || wb_i_rfwa !== 5'd7) begin
            failures++;
            $display("FAIL pass_wb wdata/rfwe/rfwa got %h/%b/%0d expected 00001234/1/7",
                     wb_i_wdata, wb_i_rfwe, wb_i_rfwa);
        end
        checks++;
        if (wb_i_mulres !== 64'h1122_3344_5566_7788 || wb_i_hilowe !== 1'b1) begin
            failures++;
            $display("FAIL pass_hilo mulres/hilowe got %h/%b expected 1122334455667788/1",
                     wb_i_mulres, wb_i_hilowe);
        end
        go_idle();
    endtask

    initial begin
        cpu_rst    = 1'b1;
        dbus_ack   = 1'b0;
        dbus_rdata = 32'h0;
        set_op(MEM_NONE, 32'h0, 32'h0);
        test_reset();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_busy();
        test_timeout();
        test_passthrough();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs and drives the MEM/WB register.
- Performs loads and stores over a variable-latency req/ack data bus, with byte-lane steering and load sign/zero extension.
- Detects misaligned accesses and stalls the upstream pipeline until each bus transaction completes.
- Non-memory results (ALU result, mul result, HI/LO write) pass through combinationally.

Parameters:
- DBUS_AW, 32, data bus byte-address width.
- TIMEOUT_CYC, 255, BUSY cycles without ack before the access is abandoned with a bus-error flag.

Ports:
- cpu_clk_50M  in  1  clock.
- cpu_rst  in  1  synchronous reset, active-high.
- mem_i_dm2rf  in  1  writeback selects load data.
- mem_i_hilowe  in  1  HI/LO write enable.
- mem_i_rfwe  in  1  register-file write enable.
- mem_i_rfwa  in  5  register-file write address.
- mem_i_mulres  in  64  multiply result.
- mem_i_alures  in  32  ALU result; effective address for memory ops.
- mem_i_dmdin  in  32  store data (rt).
- mem_i_memop  in  memop  memory operation.
- dbus_req  out  1  request valid.
- dbus_we  out  1  write.
- dbus_be  out  4  byte enables.
- dbus_addr  out  DBUS_AW  word-aligned address ({alures[31:2],2'b00}).
- dbus_wdata  out  32  lane-steered store data.
- dbus_ack  in  1  request completed; read data valid this cycle.
- dbus_rdata  in  32  read data.
- mem_stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM.
- wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe, wb_i_rfwa, wb_i_mulres  out  as inputs  pass-through to MEM/WB.
- wb_i_wdata  out  32  extended load data when dm2rf, else alures.
- mem_o_adel  out  1  load address error.
- mem_o_ades  out  1  store address error.
- mem_o_buserr  out  1  timeout error.

Behaviour:
- Reset:
  - Forces state=IDLE, load_buf=0, timeout counter=0.
  - While cpu_rst is high, all outputs are 0, dbus_req is dropped in the same cycle, and any access is abandoned.
  - The bus slave must tolerate an abandoned request.
- memop classes:
  - loads: LB, LBU, LH, LHU, LW.
  - stores: SB, SH, SW.
  - MEM_NONE: no access.
- Alignment:
  - Halfword ops need a[0]=0; word ops need a[1:0]=00, where a=mem_i_alures.
  - On violation (IDLE only): no dbus_req, no stall, wb_i_rfwe=0, and adel (load) or ades (store) =1 for that cycle.
- Store steering:
  - SB: be=0001<<a[1:0], wdata={4{dmdin[7:0]}}.
  - SH: be=a[1]?1100:0011, wdata={2{dmdin[15:0]}}.
  - SW: be=1111, wdata=dmdin.
  - Stores force wb_i_rfwe=0.
- Load extraction (little-endian), applied to dbus_rdata or load_buf:
  - Byte select = a[1:0]; halfword select = a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Loads have be=1111.
- FSM states IDLE, BUSY, DONE:
  - IDLE with an aligned access: dbus_req=1 combinationally and mem_stall=1.
    - If dbus_ack is high the same cycle: load_buf<=rdata, next state DONE.
    - Otherwise next state BUSY.
  - BUSY: hold req, be, addr, wdata and we stable; mem_stall=1; counter increments.
    - On ack: load_buf<=rdata, next state DONE.
    - If counter reaches TIMEOUT_CYC: buserr=1 for that cycle, wb_i_rfwe=0, next state DONE.
  - DONE: dbus_req=0, mem_stall=0; writeback uses load_buf; next state IDLE; counter cleared.
- Latency:
  - An access stalls for at least 1 cycle (ack in IDLE) and for 1+N cycles when ack arrives N cycles into BUSY.
  - The instruction retires into MEM/WB on the DONE cycle.
- Upstream contract: while mem_stall=1, the EX/MEM inputs stay stable.
- Ack is ignored in DONE.
- Back-to-back accesses: DONE→IDLE gives at most one request per 2 cycles.
- Pass-through: non-memory memops never stall; all wb_i_* outputs are combinational from the inputs.

Decomposition:
- mips_cpu_pkg holds:
  - memop enum: MEM_NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
  - mem_state_t.
  - the is_load/is_store/misaligned helper functions.
- One sub-module, mem_lane_align: combinational store steering and load extraction. It is reused by the test model.

Test Plan:
- LW a=0x100, ack in the IDLE cycle, rdata=0xDEADBEEF → req for 1 cycle, stall for 1 cycle; on DONE, wb_i_wdata=0xDEADBEEF, wb_i_rfwe=1.
- LB a=0x103 with rdata=0x80112233, ack after 3 BUSY cycles → 4 stall cycles, wdata=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH a=0x102, dmdin=0x0000ABCD → be=1100, wdata=0xABCDABCD, we=1, wb_i_rfwe=0.
- LW a=0x101 → no req, no stall, adel=1 for 1 cycle, rfwe=0. SW a=0x102 → ades=1.
- cpu_rst raised in the 2nd BUSY cycle → next cycle state IDLE, req=0, stall=0, all outputs 0.
- No ack for 255 BUSY cycles → buserr pulses once, rfwe=0, stall releases in the DONE cycle. memop=MEM_NONE, alures=0x1234 → wdata=0x1234 and no stall at any point.
